// File: rtl/bcd_pkg.sv
// Shared types and constants for the 3-decade BCD counter control path.
package bcd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPause,
    StClr,
    StHalt
  } ctrl_state_t;

  localparam logic [11:0] BCD_MAX       = 12'h999;
  localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;

  // A value with any nibble above 9 can never equal a real counter value.
  function automatic logic bcd_is_valid(input logic [11:0] v);
    return (v[3:0] <= BCD_DIGIT_MAX) && (v[7:4] <= BCD_DIGIT_MAX) &&
           (v[11:8] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_tick_gen.sv
// Run-gated prescaler: tick every TICK_DIV cycles of run; phase held while run is low.
module bcd_tick_gen #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q == PrescMax) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for a 000-999 BCD counter: prescaled enable, clear, alarm, lap capture.
module bcd_count_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10,
  parameter bit          WRAP     = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  input  logic [11:0] target,
  input  logic [3:0]  cnt_ones,
  input  logic [3:0]  cnt_tens,
  input  logic [3:0]  cnt_hundred,
  input  logic        cnt_done,
  output logic        cnt_enable,
  output logic        cnt_reset,
  output logic        running,
  output logic [11:0] lap_value,
  output logic        lap_valid,
  output logic        alarm,
  output logic        overflow
);

  ctrl_state_t state_q, state_d;
  logic [11:0] count;
  logic        tick, terminal, lap_ok;
  logic        tick_q, tick_d;
  logic        alarm_q, alarm_d;
  logic        lap_valid_q, lap_valid_d;
  logic        overflow_q, overflow_d;
  logic [11:0] lap_value_q, lap_value_d;

  assign count = {cnt_hundred, cnt_tens, cnt_ones};

  bcd_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (state_q == StRun),
    .clr   (state_q == StClr),
    .tick  (tick)
  );

  // Without wrap, the tick that would roll 999 over is swallowed and we halt instead.
  assign terminal   = tick && (count == BCD_MAX) && !WRAP;
  assign cnt_enable = tick && !terminal;
  assign cnt_reset  = (state_q == StClr);
  assign running    = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StClr;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StRun;
        StRun: begin
          if (terminal) begin
            state_d = StHalt;
          end else if (stop) begin
            state_d = StPause;
          end
        end
        StPause: if (start) state_d = StRun;
        StClr:   state_d = StIdle;
        StHalt:  state_d = StHalt;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    lap_ok = lap && !clear &&
             ((state_q == StRun) || (state_q == StPause) || (state_q == StHalt));
    tick_d      = cnt_enable;
    alarm_d     = tick_q && (count == target) && bcd_is_valid(target) && (state_q == StRun);
    lap_valid_d = lap_ok;
    lap_value_d = lap_value_q;
    if (state_d == StClr) begin
      lap_value_d = '0;
    end else if (lap_ok) begin
      lap_value_d = count;
    end
    if (WRAP) begin
      overflow_d = cnt_done && cnt_enable;
    end else begin
      overflow_d = (state_d == StHalt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tick_q      <= 1'b0;
      alarm_q     <= 1'b0;
      lap_valid_q <= 1'b0;
      lap_value_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      alarm_q     <= alarm_d;
      lap_valid_q <= lap_valid_d;
      lap_value_q <= lap_value_d;
      overflow_q  <= overflow_d;
    end
  end

  assign alarm     = alarm_q;
  assign lap_valid = lap_valid_q;
  assign lap_value = lap_value_q;
  assign overflow  = overflow_q;

endmodule
